// File: rtl/store_logger_pkg.sv
// store_logger_pkg: shared defaults, entry type, halt FSM encoding.
// Holds the saturating helper used by the optional drop counter.
package store_logger_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam logic [ADDR_W_DEF-1:0] HALT_ADDR_DEF = 8'hFF;
  localparam int OVF_CNT_W = 8;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } entry_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  function automatic logic [OVF_CNT_W-1:0] sat_inc(
    input logic [OVF_CNT_W-1:0] v
  );
    return (&v) ? v : v + OVF_CNT_W'(1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, registered storage, separate occupancy.
// Ports: wr_en_i/wr_data_i, rd_en_i/rd_data_o, count_o, full_o, empty_o.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Pointers wrap for free since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en_i) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_en_i) rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({wr_en_i, rd_en_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);

endmodule

// File: rtl/store_logger.sv
// store_logger: queues processor stores for draining, flags program halt.
// Optional drop counter ovf_cnt enabled by STORE_LOG_OVF_CNT_EN.
module store_logger
  import store_logger_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] HALT_ADDR = ADDR_W'(HALT_ADDR_DEF)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_W-1:0]      rw_addr,
  input  logic [DATA_W-1:0]      w,
  input  logic                   w_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_W-1:0]      out_addr,
  output logic [DATA_W-1:0]      out_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   overflow,
`ifdef STORE_LOG_OVF_CNT_EN
  output logic [OVF_CNT_W-1:0]   ovf_cnt,
`endif
  output logic                   halted
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t   wr_ent, rd_ent;
  logic   push, pop, accept, drop, halt_hit;
  logic   empty;
  state_e state_q, state_d;
  logic   overflow_q, overflow_d;

  assign push     = w_en & ~halted;
  assign pop      = out_valid & out_ready;
  // Full FIFO still takes a store if the head leaves this cycle.
  assign accept   = push & (~full | pop);
  assign drop     = push & full & ~pop;
  assign halt_hit = push & (rw_addr == HALT_ADDR);

  assign wr_ent.addr = rw_addr;
  assign wr_ent.data = w;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(ent_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (accept),
    .wr_data_i (wr_ent),
    .rd_en_i   (pop),
    .rd_data_o (rd_ent),
    .count_o   (count),
    .full_o    (full),
    .empty_o   (empty)
  );

  assign out_valid = ~empty;
  assign out_addr  = rd_ent.addr;
  assign out_data  = rd_ent.data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // A dropped halt store still ends the program.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:    if (halt_hit) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  always_comb begin
    halted = (state_q == ST_HALTED);
  end

  assign overflow_d = overflow_q | drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow_q <= 1'b0;
    else     overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;

`ifdef STORE_LOG_OVF_CNT_EN
  logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  assign ovf_cnt_d = drop ? sat_inc(ovf_cnt_q) : ovf_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_cnt_q <= '0;
    else     ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_store_logger.sv
// tb_store_logger: random and directed stores against a queue model.
// Compares every cycle at the falling edge while out of reset.
module tb_store_logger;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rw_addr = '0;
  logic [7:0] w = '0;
  logic       w_en = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_addr;
  logic [7:0] out_data;
  logic [3:0] count;
  logic       full;
  logic       overflow;
  logic       halted;
`ifdef STORE_LOG_OVF_CNT_EN
  logic [7:0] ovf_cnt;
`endif

  store_logger dut (
    .clk       (clk),
    .rst       (rst),
    .rw_addr   (rw_addr),
    .w         (w),
    .w_en      (w_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .count     (count),
    .full      (full),
    .overflow  (overflow),
`ifdef STORE_LOG_OVF_CNT_EN
    .ovf_cnt   (ovf_cnt),
`endif
    .halted    (halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] mq[$];
  bit m_halted = 0;
  bit m_ovf = 0;
  int m_ocnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_halted = 0;
    m_ovf = 0;
    m_ocnt = 0;
  endtask

  // Store semantics: halted stores vanish, full without pop drops.
  task automatic model_edge(input logic [7:0] a, input logic [7:0] d,
                            input logic en, input logic rdy);
    bit pop;
    bit nh;
    pop = (mq.size() != 0) && rdy;
    nh = 0;
    if (en && !m_halted) begin
      if (a == 8'hFF) nh = 1;
      if (mq.size() == DEPTH && !pop) begin
        m_ovf = 1;
        if (m_ocnt < 255) m_ocnt++;
      end else begin
        if (pop) mq.delete(0);
        mq.push_back({a, d});
      end
    end else if (pop) begin
      mq.delete(0);
    end
    if (nh) m_halted = 1;
  endtask

  task automatic step(input logic [7:0] a, input logic [7:0] d,
                      input logic en, input logic rdy);
    rw_addr = a;
    w = d;
    w_en = en;
    out_ready = rdy;
    @(posedge clk);
    model_edge(a, d, en, rdy);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (mq.size() != 0 && n < 20) begin
      step(8'h00, 8'h00, 1'b0, 1'b1);
      n++;
    end
    chk("drain_bound", int'(out_valid), 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("valid", int'(out_valid), int'(mq.size() != 0));
      chk("count", int'(count), mq.size());
      chk("full", int'(full), int'(mq.size() == DEPTH));
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("halted", int'(halted), int'(m_halted));
`ifdef STORE_LOG_OVF_CNT_EN
      chk("ovf_cnt", int'(ovf_cnt), m_ocnt);
`endif
      if (mq.size() != 0) begin
        chk("out_addr", int'(out_addr), int'(mq[0][15:8]));
        chk("out_data", int'(out_data), int'(mq[0][7:0]));
      end
    end
  end

  initial begin
    #12;
    chk("rst_count", int'(count), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_halt", int'(halted), 0);
    rst = 1'b0;

    step(8'h10, 8'h01, 1'b1, 1'b0);
    chk("lat1_valid", int'(out_valid), 1);
    step(8'h11, 8'h02, 1'b1, 1'b0);
    step(8'h12, 8'h03, 1'b1, 1'b0);
    chk("lit_count3", int'(count), 3);
    for (int i = 0; i < 3; i++) begin
      chk("lit_head_a", int'(out_addr), 'h10 + i);
      chk("lit_head_d", int'(out_data), 1 + i);
      step(8'h00, 8'h00, 1'b0, 1'b1);
    end
    chk("lit_empty", int'(out_valid), 0);

    for (int i = 0; i < DEPTH; i++)
      step(8'h40 + 8'(i), 8'(i), 1'b1, 1'b0);
    step(8'h20, 8'hAA, 1'b1, 1'b0);
    chk("lit_full", int'(full), 1);
    chk("lit_ovf", int'(overflow), 1);
    chk("lit_count8", int'(count), 8);
`ifdef STORE_LOG_OVF_CNT_EN
    chk("lit_ocnt1", int'(ovf_cnt), 1);
`endif
    chk("lit_head40", int'(out_addr), 'h40);

    step(8'h30, 8'h55, 1'b1, 1'b1);
    chk("lit_cnt_keep", int'(count), 8);
    chk("lit_head41", int'(out_addr), 'h41);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) begin
        chk("lit_last_a", int'(out_addr), 'h30);
        chk("lit_last_d", int'(out_data), 'h55);
      end
      step(8'h00, 8'h00, 1'b0, 1'b1);
    end

    for (int i = 0; i < 400; i++) begin
      step(8'($urandom_range(0, 254)), 8'($urandom),
           1'($urandom_range(0, 1)),
           (i < 200) ? 1'($urandom_range(0, 3) == 0)
                     : 1'($urandom_range(0, 3) != 0));
    end
    drain();

    for (int i = 0; i < 4; i++)
      step(8'h60 + 8'(i), 8'h70 + 8'(i), 1'b1, 1'b0);
    chk("lit_pre_rst", int'(count), 4);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count", int'(count), 0);
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_full", int'(full), 0);
    chk("arst_ovf", int'(overflow), 0);
    chk("arst_halt", int'(halted), 0);
`ifdef STORE_LOG_OVF_CNT_EN
    chk("arst_ocnt", int'(ovf_cnt), 0);
`endif
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_cnt", int'(count), 0);
    chk("post_rst_halt", int'(halted), 0);

    step(8'h01, 8'h11, 1'b1, 1'b0);
    step(8'hFF, 8'h2A, 1'b1, 1'b0);
    chk("lit_halted", int'(halted), 1);
    step(8'h05, 8'h09, 1'b1, 1'b0);
    chk("lit_ignored", int'(count), 2);
    chk("lit_no_ovf", int'(overflow), 0);
    chk("lit_h_head", int'(out_addr), 'h01);
    step(8'h00, 8'h00, 1'b0, 1'b1);
    chk("lit_h_last_a", int'(out_addr), 'hFF);
    chk("lit_h_last_d", int'(out_data), 'h2A);
    step(8'h00, 8'h00, 1'b0, 1'b1);
    chk("lit_h_empty", int'(out_valid), 0);
    for (int i = 0; i < 30; i++)
      step(8'($urandom), 8'($urandom), 1'b1, 1'($urandom_range(0, 1)));
    chk("lit_h_stay", int'(halted), 1);

    pulse_reset();
    for (int i = 0; i < DEPTH; i++)
      step(8'hFE, 8'(i), 1'b1, 1'b0);
    step(8'hFF, 8'hEE, 1'b1, 1'b0);
    chk("lit_hdrop_h", int'(halted), 1);
    chk("lit_hdrop_o", int'(overflow), 1);
    chk("lit_hdrop_c", int'(count), 8);

`ifdef STORE_LOG_OVF_CNT_EN
    pulse_reset();
    for (int i = 0; i < DEPTH; i++)
      step(8'h80, 8'(i), 1'b1, 1'b0);
    for (int i = 0; i < 300; i++)
      step(8'h81, 8'(i), 1'b1, 1'b0);
    chk("lit_ocnt_sat", int'(ovf_cnt), 255);
`endif

    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
